// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, I-memory request and the IF/ID pipeline latch.
// Optional macro FETCH_STALL_CNT_EN adds a saturating stall_cycles counter output.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  input  logic        disable_fetch,
  input  logic        halt,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_npc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        valid_reg, valid_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] ipc_reg, ipc_next;
  logic [31:0] inpc_reg, inpc_next;
  logic [31:0] pc_plus4;
  logic        stall_event;

  // Wraps naturally modulo 2^32.
  assign pc_plus4 = pc_reg + 32'd4;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_RESET;
      pc_reg    <= PC_INIT;
      valid_reg <= 1'b0;
      instr_reg <= 32'h0;
      ipc_reg   <= 32'h0;
      inpc_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      instr_reg <= instr_next;
      ipc_reg   <= ipc_next;
      inpc_reg  <= inpc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    valid_next  = valid_reg;
    instr_next  = instr_reg;
    ipc_next    = ipc_reg;
    inpc_next   = inpc_reg;
    stall_event = 1'b0;
    case (state_reg)
      ST_RESET: state_next = ST_FETCH;
      ST_FETCH: begin
        // Any action other than a stall leaves IF/ID empty unless a hit is captured.
        if (!disable_fetch || halt || redirect || flush) begin
          valid_next = 1'b0;
          instr_next = 32'h0;
          ipc_next   = 32'h0;
          inpc_next  = 32'h0;
        end
        if (halt) begin
          state_next = ST_HALTED;
        end else if (redirect) begin
          pc_next = redirect_pc & 32'hFFFF_FFFC;
        end else if (flush) begin
          pc_next = pc_reg;
        end else if (disable_fetch) begin
          stall_event = 1'b1;
        end else if (ihit) begin
          valid_next = 1'b1;
          instr_next = iload;
          ipc_next   = pc_reg;
          inpc_next  = pc_plus4;
          pc_next    = pc_plus4;
        end
      end
      default: state_next = state_reg;
    endcase
  end

  assign iREN       = (state_reg == ST_FETCH);
  assign iaddr      = pc_reg;
  assign ifid_valid = valid_reg;
  assign ifid_instr = instr_reg;
  assign ifid_pc    = ipc_reg;
  assign ifid_npc   = inpc_reg;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_reg <= 16'h0;
    end else if (stall_event && stall_reg != 16'hFFFF) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

  assign stall_cycles = stall_reg;
`else
  logic unused_stall;
  assign unused_stall = stall_event;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios plus random traffic checked
// against a rule-level reference model.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        flush = 1'b0;
  logic        disable_fetch = 1'b0;
  logic        halt = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] iload = 32'h0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_npc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  fetch_stage #(.PC_INIT(32'h00000000)) dut (
    .CLK(CLK), .RST(RST), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .disable_fetch(disable_fetch), .halt(halt), .ihit(ihit),
    .iload(iload), .iREN(iREN), .iaddr(iaddr), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_npc(ifid_npc)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic        iren;
    logic [31:0] iaddr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   stim_done = 0;

  // Reference model: 0 = reset, 1 = fetching, 2 = halted.
  int          m_mode = 0;
  logic [31:0] m_pc = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0, m_ipc = 32'h0, m_inpc = 32'h0;
  int          m_stall = 0;

  task automatic bubble();
    m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_inpc = 32'h0;
  endtask

  task automatic drive(input string tag, input logic r, input logic rd,
                       input logic [31:0] rp, input logic fl, input logic ds,
                       input logic ht, input logic ih, input logic [31:0] il);
    exp_t e;
    @(negedge CLK);
    RST = r; redirect = rd; redirect_pc = rp; flush = fl;
    disable_fetch = ds; halt = ht; ihit = ih; iload = il;
    if (r) begin
      m_mode = 0; m_pc = 32'h0; m_stall = 0; bubble();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (ht) begin
        bubble(); m_mode = 2;
      end else if (rd) begin
        m_pc = {rp[31:2], 2'b00}; bubble();
      end else if (fl) begin
        bubble();
      end else if (ds) begin
        if (m_stall < 65535) m_stall++;
      end else if (ih) begin
        m_valid = 1'b1; m_instr = il; m_ipc = m_pc;
        m_inpc = 32'(64'(m_pc) + 64'd4);
        m_pc = m_inpc;
      end else begin
        bubble();
      end
    end
    e.tag = tag; e.iren = (m_mode == 1); e.iaddr = m_pc; e.valid = m_valid;
    e.instr = m_instr; e.pc = m_ipc; e.npc = m_inpc; e.stall = m_stall;
    exp_q.push_back(e);
  endtask

  // Monitor: one scoreboard entry is retired per clock edge.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        ok = (iREN === e.iren) && (iaddr === e.iaddr) && (ifid_valid === e.valid) &&
             (ifid_instr === e.instr) && (ifid_pc === e.pc) && (ifid_npc === e.npc);
`ifdef FETCH_STALL_CNT_EN
        ok = ok && (int'(stall_cycles) == e.stall);
`endif
        if (!ok) begin
          bad++;
          $display("FAIL %s: got iREN=%0b iaddr=%h v=%0b instr=%h pc=%h npc=%h; want iREN=%0b iaddr=%h v=%0b instr=%h pc=%h npc=%h stall=%0d",
                   e.tag, iREN, iaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc,
                   e.iren, e.iaddr, e.valid, e.instr, e.pc, e.npc, e.stall);
        end else begin
          $display("txn %0d %s: iREN=%0b iaddr=%h v=%0b instr=%h pc=%h npc=%h ok",
                   total, e.tag, iREN, iaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc);
        end
      end
    end
  end

  initial begin
    // Reset state and basic sequential fetch A,B,C.
    drive("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    drive("reset_exit", 0, 1, 32'h40, 0, 0, 0, 1, 32'hDEAD0000);
    drive("fetch_a", 0, 0, 0, 0, 0, 0, 1, 32'hAAAA0001);
    drive("fetch_b", 0, 0, 0, 0, 0, 0, 1, 32'hBBBB0002);
    drive("fetch_c", 0, 0, 0, 0, 0, 0, 1, 32'hCCCC0003);
    // Stall for three cycles with hits present.
    for (int i = 0; i < 3; i++) drive("stall", 0, 0, 0, 0, 1, 0, 1, 32'h11110000 + i);
    drive("nohit", 0, 0, 0, 0, 0, 0, 0, 32'h0);
    // Redirect with flush and hit in the same cycle; low address bits masked.
    drive("redir_flush", 0, 1, 32'h00000103, 1, 0, 0, 1, 32'h22220000);
    drive("flush_only", 0, 0, 0, 1, 0, 0, 1, 32'h33330000);
    drive("after_flush", 0, 0, 0, 0, 0, 0, 1, 32'h44440000);
    // PC wrap at the top of the address space.
    drive("redir_top", 0, 1, 32'hFFFFFFFE, 0, 1, 0, 1, 32'h0);
    drive("wrap", 0, 0, 0, 0, 0, 0, 1, 32'h55550000);
    drive("post_wrap", 0, 0, 0, 0, 0, 0, 1, 32'h66660000);
    // Halt beats redirect; halted state ignores everything but reset.
    drive("halt", 0, 1, 32'h200, 0, 0, 1, 1, 32'h77770000);
    drive("halted_1", 0, 1, 32'h300, 1, 0, 0, 1, 32'h88880000);
    drive("halted_2", 0, 0, 0, 0, 0, 0, 1, 32'h99990000);
    // Reset coincident with a hit mid-fetch.
    drive("reset2", 1, 0, 0, 0, 0, 0, 0, 0);
    drive("reset2_exit", 0, 0, 0, 0, 0, 0, 1, 32'h0);
    drive("fetch_d", 0, 0, 0, 0, 0, 0, 1, 32'hDDDD0004);
    drive("rst_hit", 1, 0, 0, 0, 0, 0, 1, 32'hEEEE0005);
    drive("rst_hit_1", 0, 0, 0, 0, 0, 0, 1, 32'hEEEE0006);
    drive("rst_hit_2", 0, 0, 0, 0, 0, 0, 1, 32'hEEEE0007);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 8), rp,
            ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), $urandom);
    end
    for (int i = 0; i < 3 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    stim_done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h00000000, meaning PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  rising-edge clock; all state updates on this edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port redirect  input  1  branch/jump resolved taken; load redirect_pc.
REQ-005 SHALL have port redirect_pc  input  32  redirect target address.
REQ-006 SHALL have port flush  input  1  squash IF/ID contents this cycle.
REQ-007 SHALL have port disable_fetch  input  1  hold PC and IF/ID (data-hazard stall).
REQ-008 SHALL have port halt  input  1  halt retired; stop fetching.
REQ-009 SHALL have port ihit  input  1  instruction memory returns valid iload this cycle.
REQ-010 SHALL have port iload  input  32  fetched instruction word.
REQ-011 SHALL have port iREN  output  1  instruction read request.
REQ-012 SHALL have port iaddr  output  32  instruction read address (current PC).
REQ-013 SHALL have port ifid_valid  output  1  IF/ID latch holds a real instruction.
REQ-014 SHALL have port ifid_instr  output  32  latched instruction; 32'h0 (nop) when not valid.
REQ-015 SHALL have port ifid_pc  output  32  PC of latched instruction.
REQ-016 SHALL have port ifid_npc  output  32  ifid_pc + 4.
REQ-017 SHALL have port stall_cycles  output  16  stall counter (present only under FETCH_STALL_CNT_EN).

Function
REQ-018 SHALL implement states RESET, FETCH, HALTED; RESET->FETCH unconditionally next cycle; FETCH->HALTED on halt; HALTED exited only by RST.
REQ-019 SHALL drive iREN=1 and iaddr=PC in FETCH; iREN=0 in RESET and HALTED, iaddr=PC always.
REQ-020 SHALL apply per-cycle priority in FETCH: halt > redirect > flush > disable_fetch > ihit.
REQ-021 halt: PC held, IF/ID cleared (valid=0, instr/pc/npc=0), enter HALTED.
REQ-022 redirect: PC <= {redirect_pc[31:2],2'b00}, IF/ID cleared, any ihit data same cycle discarded.
REQ-023 flush without redirect: IF/ID cleared, PC held (instruction refetched), ihit data discarded.
REQ-024 disable_fetch: PC and all IF/ID outputs held unchanged, ihit data discarded.
REQ-025 ihit with none of the above: IF/ID <= {valid=1, instr=iload, pc=PC, npc=PC+4}, PC <= PC+4, one-cycle latency.
REQ-026 no ihit and none of the above: PC held, IF/ID cleared (bubble).
REQ-027 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-028 inputs other than RST SHALL be ignored in RESET and HALTED.

Reset
REQ-029 On RST high at a clock edge: state=RESET, PC=PC_INIT, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_npc=0, stall_cycles=0.
REQ-030 RST asserted mid-fetch SHALL discard any ihit data the same cycle and override all other inputs.
REQ-031 First iREN=1 SHALL occur the cycle after RST deasserts.

Configuration
REQ-032 Macro FETCH_STALL_CNT_EN defined: stall_cycles increments by 1 each FETCH cycle with disable_fetch=1 and no halt/redirect/flush, saturating at 16'hFFFF.
REQ-033 Macro FETCH_STALL_CNT_EN undefined: stall_cycles port and counter absent; all other behaviour identical.

Verification
REQ-034 Reset with PC_INIT=0, ihit=1 each cycle, iload=A,B,C -> iaddr 0,4,8; ifid_instr A,B,C one cycle after each; ifid_npc 4,8,12.
REQ-035 disable_fetch=1 for 3 cycles with ihit=1 -> PC and IF/ID frozen; with macro, stall_cycles=3.
REQ-036 redirect=1, redirect_pc=32'h00000103, flush=1, ihit=1 same cycle -> next iaddr=32'h00000100, ifid_valid=0, ifid_instr=0.
REQ-037 PC=32'hFFFFFFFC, ihit=1 -> next iaddr=32'h00000000, ifid_npc=32'h00000000.
REQ-038 halt=1 with redirect=1 -> HALTED, iREN=0, PC unchanged, IF/ID cleared; further ihit/redirect ignored until RST.
REQ-039 RST=1 coincident with ihit -> PC=PC_INIT, ifid_valid=0, iREN=0 that next cycle, iREN=1 the following cycle.
